// File: rtl/legv8_ctrl_pkg.sv
// Shared definitions for the multi-cycle LEGv8 main control unit.
// Holds the FSM state encoding, the opcode-class encoding, the opcode
// constants that identify each supported instruction, and the datapath
// mux/ALU operation encodings driven by the controller.
package legv8_ctrl_pkg;

    // Controller states
    typedef enum logic [3:0] {
        RST    = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        EXEC_R = 4'd3,
        ALU_WB = 4'd4,
        ADDR   = 4'd5,
        MEM_RD = 4'd6,
        MEM_WB = 4'd7,
        MEM_WR = 4'd8,
        BR_CBZ = 4'd9,
        BR_B   = 4'd10,
        TRAP   = 4'd11
    } state_e;

    // Instruction classes recognised by the decoder
    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_LDUR    = 3'd1,
        CLS_STUR    = 3'd2,
        CLS_CBZ     = 3'd3,
        CLS_B       = 3'd4,
        CLS_ILLEGAL = 3'd5
    } opc_class_e;

    // Opcode constants (Instruction[31:21]); B and CBZ match on a prefix only
    localparam logic [5:0]  OPC_B_PFX   = 6'b000101;
    localparam logic [7:0]  OPC_CBZ_PFX = 8'b10110100;
    localparam logic [10:0] OPC_LDUR    = 11'b11111000010;
    localparam logic [10:0] OPC_STUR    = 11'b11111000000;
    localparam logic [10:0] OPC_ADD     = 11'b10001011000;
    localparam logic [10:0] OPC_SUB     = 11'b11001011000;
    localparam logic [10:0] OPC_AND     = 11'b10001010000;
    localparam logic [10:0] OPC_ORR     = 11'b10101010000;

    // ALU_Op encodings consumed by the ALU control decoder
    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_PASS_B = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;

    // ALU input A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_REG   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    // ALU input B select
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_DOFF  = 2'b10;
    localparam logic [1:0] SRCB_BROFF = 2'b11;

endpackage

// File: rtl/legv8_opcode_class.sv
// Combinational opcode classifier.
// Ports:
//   opcode_field : Instruction[31:21] from the instruction register
//   opc_class    : decoded instruction class (B, CBZ, LDUR, STUR, R, ILLEGAL)
// B and CBZ are checked first because they are prefix matches and take
// priority over the full-width comparisons.
module legv8_opcode_class
    import legv8_ctrl_pkg::*;
(
    input  logic [10:0] opcode_field,
    output opc_class_e  opc_class
);

    // Prioritised opcode-to-class decode
    always_comb begin
        opc_class = CLS_ILLEGAL;
        if (opcode_field[10:5] == OPC_B_PFX) begin
            opc_class = CLS_B;
        end else if (opcode_field[10:3] == OPC_CBZ_PFX) begin
            opc_class = CLS_CBZ;
        end else begin
            case (opcode_field)
                OPC_LDUR: opc_class = CLS_LDUR;
                OPC_STUR: opc_class = CLS_STUR;
                OPC_ADD,
                OPC_SUB,
                OPC_AND,
                OPC_ORR:  opc_class = CLS_R;
                default:  opc_class = CLS_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/legv8_multicycle_control.sv
// Main control FSM for the multi-cycle LEGv8 datapath.
// Sequences fetch/decode/execute/memory/writeback, handshakes with a
// variable-latency memory through Mem_ready, and counts retired instructions.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   Opcode_field        : Instruction[31:21] from the instruction register
//   Zero                : ALU zero flag (qualifies the CBZ PC write)
//   Mem_ready           : memory done, only looked at while a request is up
//   PCWrite .. PCSource : datapath enables, write strobes and mux selects
//   Illegal             : high while parked in TRAP (left only by reset)
//   Instr_Count         : retired-instruction counter, wraps modulo 2^RETIRE_W
// Outputs are a Moore decode of the state register so that an asserted
// rst_n drops every strobe immediately; only the FETCH/MEM_WR/CBZ strobes
// that are qualified by Mem_ready or Zero look at live inputs.
module legv8_multicycle_control
    import legv8_ctrl_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [10:0]         Opcode_field,
    input  logic                Zero,
    input  logic                Mem_ready,
    output logic                PCWrite,
    output logic                IRWrite,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic                Reg2Loc,
    output logic [1:0]          ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALU_Op,
    output logic                PCSource,
    output logic                Illegal,
    output logic [RETIRE_W-1:0] Instr_Count
);

    localparam logic [RETIRE_W-1:0] CNT_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

    state_e              state_q;
    state_e              state_d;
    logic [RETIRE_W-1:0] count_q;
    logic [RETIRE_W-1:0] count_d;
    logic                retire_s;
    opc_class_e          opc_class_s;

    legv8_opcode_class u_opcode_class (
        .opcode_field (Opcode_field),
        .opc_class    (opc_class_s)
    );

    // State and retire-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state, retire pulse and Moore output decode
    always_comb begin
        state_d  = state_q;
        retire_s = 1'b0;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = SRCA_PC;
        ALUSrcB  = SRCB_REG;
        ALU_Op   = ALU_OP_ADD;
        PCSource = 1'b0;
        Illegal  = 1'b0;

        case (state_q)
            RST: begin
                state_d = FETCH;
            end
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcA = SRCA_PC;
                ALUSrcB = SRCB_FOUR;
                ALU_Op  = ALU_OP_ADD;
                // IR and PC+4 are committed on the same edge the memory completes
                IRWrite = Mem_ready;
                PCWrite = Mem_ready;
                if (Mem_ready) begin
                    state_d = DECODE;
                end else begin
                    state_d = FETCH;
                end
            end
            DECODE: begin
                // Speculatively form the branch target into ALUOut
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_BROFF;
                ALU_Op  = ALU_OP_ADD;
                case (opc_class_s)
                    CLS_R:    state_d = EXEC_R;
                    CLS_LDUR: state_d = ADDR;
                    CLS_STUR: state_d = ADDR;
                    CLS_CBZ:  state_d = BR_CBZ;
                    CLS_B:    state_d = BR_B;
                    default:  state_d = TRAP;
                endcase
            end
            EXEC_R: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_REG;
                ALU_Op  = ALU_OP_RTYPE;
                state_d = ALU_WB;
            end
            ALU_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b0;
                retire_s = 1'b1;
                state_d  = FETCH;
            end
            ADDR: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_DOFF;
                ALU_Op  = ALU_OP_ADD;
                if (opc_class_s == CLS_STUR) begin
                    state_d = MEM_WR;
                end else begin
                    state_d = MEM_RD;
                end
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (Mem_ready) begin
                    state_d = MEM_WB;
                end else begin
                    state_d = MEM_RD;
                end
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire_s = 1'b1;
                state_d  = FETCH;
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (Mem_ready) begin
                    retire_s = 1'b1;
                    state_d  = FETCH;
                end else begin
                    state_d  = MEM_WR;
                end
            end
            BR_CBZ: begin
                // Pass Rt through the ALU; Zero decides whether ALUOut loads PC
                ALUSrcA  = SRCA_REG;
                ALUSrcB  = SRCB_REG;
                ALU_Op   = ALU_OP_PASS_B;
                PCSource = 1'b1;
                PCWrite  = Zero;
                retire_s = 1'b1;
                state_d  = FETCH;
            end
            BR_B: begin
                PCWrite  = 1'b1;
                PCSource = 1'b1;
                retire_s = 1'b1;
                state_d  = FETCH;
            end
            TRAP: begin
                Illegal = 1'b1;
                state_d = TRAP;
            end
            default: begin
                state_d = RST;
            end
        endcase

        // CBZ and STUR read Rt on port 2; RST keeps every output low
        if ((state_q != RST) &&
            ((opc_class_s == CLS_STUR) || (opc_class_s == CLS_CBZ))) begin
            Reg2Loc = 1'b1;
        end else begin
            Reg2Loc = 1'b0;
        end

        if (retire_s) begin
            count_d = count_q + CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    assign Instr_Count = count_q;

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// Scoreboard bench for legv8_multicycle_control. The driver issues one
// cycle of stimulus at each falling edge and queues the expected outputs;
// the monitor pops and compares shortly after. A second instance with a
// 4-bit counter shares every input to observe counter wrap-around.
module tb_legv8_multicycle_control;

    localparam logic [10:0] O_ADD  = 11'b10001011000;
    localparam logic [10:0] O_SUB  = 11'b11001011000;
    localparam logic [10:0] O_AND  = 11'b10001010000;
    localparam logic [10:0] O_ORR  = 11'b10101010000;
    localparam logic [10:0] O_LDUR = 11'b11111000010;
    localparam logic [10:0] O_STUR = 11'b11111000000;
    localparam logic [10:0] O_CBZ  = 11'b10110100101;
    localparam logic [10:0] O_B    = 11'b00010110011;
    localparam logic [10:0] O_ILL  = 11'b00000000000;

    typedef struct packed {
        logic        pcw;
        logic        irw;
        logic        iord;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        rw;
        logic        r2l;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic [1:0]  aop;
        logic        pcs;
        logic        ill;
        logic [31:0] cnt;
    } out_t;

    typedef struct {
        out_t  v;
        string n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] Opcode_field;
    logic        Zero;
    logic        Mem_ready;

    logic        PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegWrite, Reg2Loc;
    logic [1:0]  ALUSrcA, ALUSrcB, ALU_Op;
    logic        PCSource, Illegal;
    logic [31:0] Instr_Count;

    logic        w4_pcw, w4_irw, w4_iord, w4_mr, w4_mw, w4_m2r, w4_rw, w4_r2l;
    logic [1:0]  w4_sa, w4_sb, w4_aop;
    logic        w4_pcs, w4_ill;
    logic [3:0]  w4_cnt;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    logic [10:0] opc;
    logic [31:0] cnt;
    out_t        act;
    out_t        act4;

    always #5 clk = ~clk;

    legv8_multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .Opcode_field(Opcode_field), .Zero(Zero),
        .Mem_ready(Mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .Reg2Loc(Reg2Loc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALU_Op(ALU_Op), .PCSource(PCSource),
        .Illegal(Illegal), .Instr_Count(Instr_Count)
    );

    legv8_multicycle_control #(.RETIRE_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .Opcode_field(Opcode_field), .Zero(Zero),
        .Mem_ready(Mem_ready), .PCWrite(w4_pcw), .IRWrite(w4_irw), .IorD(w4_iord),
        .MemRead(w4_mr), .MemWrite(w4_mw), .MemtoReg(w4_m2r),
        .RegWrite(w4_rw), .Reg2Loc(w4_r2l), .ALUSrcA(w4_sa),
        .ALUSrcB(w4_sb), .ALU_Op(w4_aop), .PCSource(w4_pcs),
        .Illegal(w4_ill), .Instr_Count(w4_cnt)
    );

    assign act  = {PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegWrite, Reg2Loc,
                   ALUSrcA, ALUSrcB, ALU_Op, PCSource, Illegal, Instr_Count};
    assign act4 = {w4_pcw, w4_irw, w4_iord, w4_mr, w4_mw, w4_m2r, w4_rw, w4_r2l,
                   w4_sa, w4_sb, w4_aop, w4_pcs, w4_ill, 28'h0000000, w4_cnt};

    // Expected-value builders, one per state, straight from the state table
    function automatic out_t base(input bit in_rst);
        out_t e;
        e = '0;
        e.cnt = cnt;
        if (!in_rst && ((opc == O_STUR) || (opc[10:3] == 8'b10110100))) e.r2l = 1'b1;
        return e;
    endfunction

    function automatic out_t e_rst();
        return base(1'b1);
    endfunction

    function automatic out_t e_fetch(input bit rdy);
        out_t e;
        e = base(1'b0);
        e.mr = 1'b1; e.sb = 2'b01; e.irw = rdy; e.pcw = rdy;
        return e;
    endfunction

    function automatic out_t e_decode();
        out_t e;
        e = base(1'b0);
        e.sa = 2'b10; e.sb = 2'b11;
        return e;
    endfunction

    function automatic out_t e_exec_r();
        out_t e;
        e = base(1'b0);
        e.sa = 2'b01; e.aop = 2'b10;
        return e;
    endfunction

    function automatic out_t e_alu_wb();
        out_t e;
        e = base(1'b0);
        e.rw = 1'b1;
        return e;
    endfunction

    function automatic out_t e_addr();
        out_t e;
        e = base(1'b0);
        e.sa = 2'b01; e.sb = 2'b10;
        return e;
    endfunction

    function automatic out_t e_mem_rd();
        out_t e;
        e = base(1'b0);
        e.mr = 1'b1; e.iord = 1'b1;
        return e;
    endfunction

    function automatic out_t e_mem_wb();
        out_t e;
        e = base(1'b0);
        e.rw = 1'b1; e.m2r = 1'b1;
        return e;
    endfunction

    function automatic out_t e_mem_wr();
        out_t e;
        e = base(1'b0);
        e.mw = 1'b1; e.iord = 1'b1;
        return e;
    endfunction

    function automatic out_t e_cbz(input bit z);
        out_t e;
        e = base(1'b0);
        e.sa = 2'b01; e.aop = 2'b01; e.pcs = 1'b1; e.pcw = z;
        return e;
    endfunction

    function automatic out_t e_br_b();
        out_t e;
        e = base(1'b0);
        e.pcw = 1'b1; e.pcs = 1'b1;
        return e;
    endfunction

    function automatic out_t e_trap();
        out_t e;
        e = base(1'b0);
        e.ill = 1'b1;
        return e;
    endfunction

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, got, want);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, advance to next falling edge
    task automatic step(input string n, input out_t e, input bit rdy, input bit z);
        exp_t x;
        Opcode_field = opc;
        Mem_ready    = rdy;
        Zero         = z;
        x.v = e;
        x.n = n;
        q.push_back(x);
        @(negedge clk);
    endtask

    task automatic run_r(input logic [10:0] o);
        opc = o;
        step("r_fetch", e_fetch(1'b1), 1'b1, 1'b0);
        step("r_decode", e_decode(), 1'b1, 1'b1);
        step("r_exec", e_exec_r(), 1'b0, 1'b0);
        step("r_wb", e_alu_wb(), 1'b1, 1'b1);
        cnt++;
    endtask

    task automatic run_b(input string n);
        opc = O_B;
        step({n, "_fetch"}, e_fetch(1'b1), 1'b1, 1'b0);
        step({n, "_decode"}, e_decode(), 1'b1, 1'b0);
        step({n, "_br"}, e_br_b(), 1'b0, 1'b0);
        cnt++;
    endtask

    task automatic run_cbz(input bit z);
        opc = O_CBZ;
        step("cbz_fetch", e_fetch(1'b1), 1'b1, 1'b0);
        step("cbz_decode", e_decode(), 1'b1, 1'b0);
        step("cbz_br", e_cbz(z), 1'b1, z);
        cnt++;
    endtask

    // Assert reset on the current falling edge, release on the next
    task automatic do_reset(input string n);
        rst_n = 1'b0;
        #1;
        chk({n, "_outputs_zero"}, {12'h000, act}, 64'h0);
        cnt = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        step({n, "_rst_state"}, e_rst(), 1'b1, 1'b0);
    endtask

    // Monitor: compare both instances against the queued expectation
    always @(negedge clk) begin
        #2;
        if (q.size() > 0) begin
            exp_t x;
            out_t e4;
            x = q.pop_front();
            e4 = x.v;
            e4.cnt = {28'h0000000, x.v.cnt[3:0]};
            total++;
            if (act !== x.v) begin
                bad++;
                $display("FAIL %s: got %h want %h", x.n, act, x.v);
            end
            total++;
            if (act4 !== e4) begin
                bad++;
                $display("FAIL %s_w4: got %h want %h", x.n, act4, e4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        Opcode_field = 11'd0;
        Zero         = 1'b0;
        Mem_ready    = 1'b0;
        opc          = O_ILL;
        cnt          = 32'd0;
        #12;
        chk("reset_outputs", {12'h000, act}, 64'h0);
        chk("reset_count4", {60'h0, w4_cnt}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step("rst_state", e_rst(), 1'b1, 1'b0);

        // R-type with and without a FETCH wait cycle
        run_r(O_ADD);
        chk("add_count", {32'h0, Instr_Count}, 64'd1);
        opc = O_SUB;
        step("sub_fetch_wait", e_fetch(1'b0), 1'b0, 1'b0);
        run_r(O_SUB);
        run_r(O_AND);
        run_r(O_ORR);

        // LDUR with 3 wait cycles in MEM_RD: 8 cycles total
        opc = O_LDUR;
        step("ldur_fetch", e_fetch(1'b1), 1'b1, 1'b0);
        step("ldur_decode", e_decode(), 1'b1, 1'b0);
        step("ldur_addr", e_addr(), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("ldur_memrd_wait", e_mem_rd(), 1'b0, 1'b1);
        step("ldur_memrd_done", e_mem_rd(), 1'b1, 1'b0);
        step("ldur_memwb", e_mem_wb(), 1'b0, 1'b0);
        cnt++;

        // STUR, no wait
        opc = O_STUR;
        step("stur_fetch", e_fetch(1'b1), 1'b1, 1'b0);
        step("stur_decode", e_decode(), 1'b1, 1'b0);
        step("stur_addr", e_addr(), 1'b0, 1'b0);
        step("stur_memwr", e_mem_wr(), 1'b1, 1'b0);
        cnt++;

        // CBZ taken and not taken, then B
        run_cbz(1'b1);
        run_cbz(1'b0);
        run_b("b");
        chk("count_after_mix", {32'h0, Instr_Count}, 64'd9);

        // Illegal opcode parks in TRAP regardless of Mem_ready
        opc = O_ILL;
        step("ill_fetch", e_fetch(1'b1), 1'b1, 1'b0);
        step("ill_decode", e_decode(), 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step("trap_hold", e_trap(), i[0], 1'b1);
        chk("trap_count_kept", {32'h0, Instr_Count}, 64'd9);
        do_reset("trap_reset");
        run_r(O_ADD);

        // Reset while STUR waits in MEM_WR
        opc = O_STUR;
        step("stur2_fetch", e_fetch(1'b1), 1'b1, 1'b0);
        step("stur2_decode", e_decode(), 1'b1, 1'b0);
        step("stur2_addr", e_addr(), 1'b0, 1'b0);
        step("stur2_memwr_wait", e_mem_wr(), 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("memwrite_async_drop", {63'h0, MemWrite}, 64'h0);
        chk("count_async_clear", {32'h0, Instr_Count}, 64'h0);
        cnt = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        step("stur2_rst_state", e_rst(), 1'b0, 1'b0);
        run_r(O_ADD);

        // 17 back-to-back B: the 4-bit counter wraps 15 -> 0 -> 1
        do_reset("wrap_reset");
        for (int i = 0; i < 16; i++) run_b("wrap_b");
        chk("wrap_count4_zero", {60'h0, w4_cnt}, 64'h0);
        run_b("wrap_b17");
        chk("wrap_count4_one", {60'h0, w4_cnt}, 64'd1);
        chk("wrap_count32", {32'h0, Instr_Count}, 64'd17);

        #3;
        chk("queue_drained", 64'(q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
